// File: rtl/multicycle_controller.sv
// Main control FSM for a multicycle MIPS-style datapath.
// Moore outputs come from the state register; write strobes are held low while reset is asserted.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [3:0] state,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q, state_d;
  logic       decodeToFetch;
  logic       functLegal;
  logic [2:0] functAluCtl;
  logic       irWriteRaw, pcWriteRaw, regWriteRaw, memWriteRaw, branchRaw, doneRaw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    functLegal  = 1'b1;
    functAluCtl = 3'b010;
    case (funct)
      6'b100000: functAluCtl = 3'b010;
      6'b100010: functAluCtl = 3'b110;
      6'b100100: functAluCtl = 3'b000;
      6'b100101: functAluCtl = 3'b001;
      6'b101010: functAluCtl = 3'b111;
      default:   functLegal  = 1'b0;
    endcase
  end

  // Unknown opcodes and R-types with unsupported funct retire straight from DECODE.
  always_comb begin
    state_d       = FETCH;
    decodeToFetch = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = functLegal ? EXECUTE : FETCH;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
        decodeToFetch = (state_d == FETCH);
      end
      MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    IorD        = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    PCSrc       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUControl  = 3'b010;
    irWriteRaw  = 1'b0;
    pcWriteRaw  = 1'b0;
    regWriteRaw = 1'b0;
    memWriteRaw = 1'b0;
    branchRaw   = 1'b0;
    doneRaw     = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB    = 2'b01;
        irWriteRaw = 1'b1;
        pcWriteRaw = 1'b1;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        doneRaw = decodeToFetch;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        MemtoReg    = 1'b1;
        regWriteRaw = 1'b1;
        doneRaw     = 1'b1;
      end
      MEMWR: begin
        IorD        = 1'b1;
        memWriteRaw = 1'b1;
        doneRaw     = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = functAluCtl;
      end
      ALUWB: begin
        RegDst      = 1'b1;
        regWriteRaw = 1'b1;
        doneRaw     = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b110;
        PCSrc      = 2'b01;
        branchRaw  = 1'b1;
        doneRaw    = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        regWriteRaw = 1'b1;
        doneRaw     = 1'b1;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        pcWriteRaw = 1'b1;
        doneRaw    = 1'b1;
      end
      default: ;
    endcase
  end

  assign IRWrite    = irWriteRaw  & rst_n;
  assign PCWrite    = pcWriteRaw  & rst_n;
  assign RegWrite   = regWriteRaw & rst_n;
  assign MemWrite   = memWriteRaw & rst_n;
  assign Branch     = branchRaw   & rst_n;
  assign instr_done = doneRaw     & rst_n;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its
// state sequence and checks outputs at the falling edge against hand-derived values.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       IorD, MemWrite, IRWrite, PCWrite, Branch, RegWrite, RegDst, MemtoReg;
  logic [1:0] PCSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] state;
  logic       instr_done;

  int compared   = 0;
  int mismatched = 0;
  int doneCnt, regWriteCnt, memWriteCnt, iordCnt;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .state(state), .instr_done(instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn);
    opcode      = op;
    funct       = fn;
    doneCnt     = 0;
    regWriteCnt = 0;
    memWriteCnt = 0;
    iordCnt     = 0;
  endtask

  // Advance to the next falling edge and tally strobes seen in that cycle.
  task automatic nextCycle();
    @(negedge clk);
    if (instr_done) doneCnt++;
    if (RegWrite)   regWriteCnt++;
    if (MemWrite)   memWriteCnt++;
    if (IorD)       iordCnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(6'b100011, 6'b000000);
    #2;
    checkOutput("rst state",    state, 0);
    checkOutput("rst IRWrite",  IRWrite, 0);
    checkOutput("rst PCWrite",  PCWrite, 0);
    checkOutput("rst ALUSrcB",  ALUSrcB, 1);
    checkOutput("rst done",     instr_done, 0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("fetch IRWrite", IRWrite, 1);
    checkOutput("fetch PCWrite", PCWrite, 1);
    checkOutput("fetch IorD",    IorD, 0);

    // lw: 0,1,2,3,4,0
    nextCycle(); checkOutput("lw s1", state, 1); checkOutput("lw dec ALUSrcB", ALUSrcB, 3);
    nextCycle(); checkOutput("lw s2", state, 2); checkOutput("lw adr ALUSrcB", ALUSrcB, 2);
    checkOutput("lw adr ALUSrcA", ALUSrcA, 1);
    nextCycle(); checkOutput("lw s3", state, 3); checkOutput("lw rd IorD", IorD, 1);
    nextCycle(); checkOutput("lw s4", state, 4); checkOutput("lw wb MemtoReg", MemtoReg, 1);
    checkOutput("lw wb RegWrite", RegWrite, 1);
    nextCycle(); checkOutput("lw s0", state, 0);
    checkOutput("lw done count", doneCnt, 1);
    checkOutput("lw regwrite count", regWriteCnt, 1);

    // sw: 0,1,2,5,0
    applyStimulus(6'b101011, 6'b000000);
    nextCycle(); checkOutput("sw s1", state, 1);
    nextCycle(); checkOutput("sw s2", state, 2);
    nextCycle(); checkOutput("sw s5", state, 5);
    nextCycle(); checkOutput("sw s0", state, 0);
    checkOutput("sw memwrite count", memWriteCnt, 1);
    checkOutput("sw iord count", iordCnt, 1);
    checkOutput("sw regwrite count", regWriteCnt, 0);

    // slt: 0,1,6,7,0
    applyStimulus(6'b000000, 6'b101010);
    nextCycle(); checkOutput("slt s1", state, 1);
    nextCycle(); checkOutput("slt s6", state, 6); checkOutput("slt ALUControl", ALUControl, 7);
    checkOutput("slt ALUSrcB", ALUSrcB, 0);
    nextCycle(); checkOutput("slt s7", state, 7); checkOutput("slt RegDst", RegDst, 1);
    checkOutput("slt RegWrite", RegWrite, 1);
    nextCycle(); checkOutput("slt s0", state, 0);

    // sub through EXECUTE for a second ALUControl value
    applyStimulus(6'b000000, 6'b100010);
    nextCycle(); nextCycle();
    checkOutput("sub s6", state, 6); checkOutput("sub ALUControl", ALUControl, 6);
    nextCycle(); nextCycle(); checkOutput("sub s0", state, 0);

    // R-type with unsupported funct: 0,1,0
    applyStimulus(6'b000000, 6'b001111);
    nextCycle(); checkOutput("badfn s1", state, 1); checkOutput("badfn done", instr_done, 1);
    nextCycle(); checkOutput("badfn s0", state, 0);
    checkOutput("badfn regwrite count", regWriteCnt, 0);

    // beq: 0,1,8,0
    applyStimulus(6'b000100, 6'b000000);
    nextCycle(); checkOutput("beq s1", state, 1); checkOutput("beq dec done", instr_done, 0);
    nextCycle(); checkOutput("beq s8", state, 8); checkOutput("beq Branch", Branch, 1);
    checkOutput("beq PCSrc", PCSrc, 1); checkOutput("beq ALUControl", ALUControl, 6);
    nextCycle(); checkOutput("beq s0", state, 0);

    // j: 0,1,11,0
    applyStimulus(6'b000010, 6'b000000);
    nextCycle(); checkOutput("j s1", state, 1);
    nextCycle(); checkOutput("j s11", state, 11); checkOutput("j PCWrite", PCWrite, 1);
    checkOutput("j PCSrc", PCSrc, 2);
    nextCycle(); checkOutput("j s0", state, 0);

    // addi: 0,1,9,10,0
    applyStimulus(6'b001000, 6'b000000);
    nextCycle(); checkOutput("addi s1", state, 1);
    nextCycle(); checkOutput("addi s9", state, 9); checkOutput("addi ALUSrcB", ALUSrcB, 2);
    nextCycle(); checkOutput("addi s10", state, 10); checkOutput("addi RegWrite", RegWrite, 1);
    checkOutput("addi RegDst", RegDst, 0);
    nextCycle(); checkOutput("addi s0", state, 0);

    // unknown opcode: 0,1,0
    applyStimulus(6'b111111, 6'b000000);
    nextCycle(); checkOutput("nop s1", state, 1); checkOutput("nop done", instr_done, 1);
    nextCycle(); checkOutput("nop s0", state, 0);

    // Reset while in MEMRD, between edges
    applyStimulus(6'b100011, 6'b000000);
    nextCycle(); nextCycle(); nextCycle();
    checkOutput("mid s3", state, 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid rst state", state, 0);
    checkOutput("mid rst IRWrite", IRWrite, 0);
    checkOutput("mid rst PCWrite", PCWrite, 0);
    checkOutput("mid rst IorD", IorD, 0);
    @(posedge clk); #1;
    checkOutput("mid hold state", state, 0);
    checkOutput("mid hold IRWrite", IRWrite, 0);
    checkOutput("mid hold RegWrite", RegWrite, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("mid rel IRWrite", IRWrite, 1);
    nextCycle(); checkOutput("mid rel s1", state, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: none; encodings below are fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instr[31:26] from the datapath instruction register.
REQ-005 funct  input  6  instr[5:0] from the datapath instruction register.
REQ-006 IorD  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-007 MemWrite  output  1  data memory write strobe.
REQ-008 IRWrite  output  1  instruction register load.
REQ-009 PCWrite  output  1  unconditional PC load.
REQ-010 Branch  output  1  conditional PC load, gated with zero by the datapath.
REQ-011 RegWrite, RegDst, MemtoReg  output  1 each  register-file write, dest select (1=rd), writeback source (1=memory).
REQ-012 PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target.
REQ-013 ALUSrcA  output  1  0=PC, 1=rs value.
REQ-014 ALUSrcB  output  2  00=rt value, 01=constant 4, 10=sign_ext, 11=sign_ext<<2.
REQ-015 ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-016 state  output  4  current state code, for debug.
REQ-017 instr_done  output  1  one-cycle pulse in the final state of each instruction.

Function
REQ-018 The block SHALL be a Moore FSM: all outputs decode from the state register only, and outputs not listed for a state are 0 (ALUControl 010).
REQ-019 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-020 FETCH outputs: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, IRWrite=1, PCWrite=1; next state DECODE.
REQ-021 DECODE outputs: ALUSrcA=0, ALUSrcB=11, add. Next state by opcode: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other opcode -> FETCH (no-op).
REQ-022 An R-type whose funct is not one of 100000, 100010, 100100, 100101, 101010 SHALL go DECODE -> FETCH with no register write.
REQ-023 MEMADR outputs: ALUSrcA=1, ALUSrcB=10, add; next state MEMRD for lw, MEMWR for sw (decided by opcode held in IR).
REQ-024 MEMRD: IorD=1 -> MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH. MEMWR: IorD=1, MemWrite=1 -> FETCH.
REQ-025 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from funct (add 010, sub 110, and 000, or 001, slt 111) -> ALUWB. ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-026 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1 -> FETCH.
REQ-027 ADDIEX: ALUSrcA=1, ALUSrcB=10, add -> ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-028 JUMP: PCSrc=10, PCWrite=1 -> FETCH.
REQ-029 instr_done SHALL be 1 in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP, and in DECODE when DECODE's next state is FETCH.
REQ-030 Latency from FETCH to FETCH: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal/no-op 2.
REQ-031 opcode and funct SHALL be sampled only in DECODE, MEMADR and EXECUTE; they are stable after the FETCH edge because the IR loads only when IRWrite=1.

Reset
REQ-032 rst_n low SHALL force state to FETCH immediately, without waiting for a clock edge.
REQ-033 While rst_n is low, IRWrite, PCWrite, RegWrite, MemWrite, Branch and instr_done SHALL be forced to 0; the other outputs show FETCH values.
REQ-034 Reset asserted mid-instruction SHALL abandon the instruction with no further write strobes; the first rising edge after release executes FETCH with strobes enabled.

Verification
REQ-035 Reset release, opcode=100011 held -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; instr_done pulses once.
REQ-036 opcode=101011 -> sequence 0,1,2,5,0; MemWrite=1 and IorD=1 for exactly one cycle; RegWrite never 1.
REQ-037 opcode=000000, funct=101010 -> sequence 0,1,6,7,0; ALUControl=111 in state 6; RegDst=1 and RegWrite=1 in state 7. Then funct=001111 -> sequence 0,1,0 with no RegWrite.
REQ-038 opcode=000100 -> sequence 0,1,8,0 with Branch=1, PCSrc=01, ALUControl=110 in state 8. opcode=000010 -> sequence 0,1,11,0 with PCWrite=1, PCSrc=10 in state 11.
REQ-039 opcode=111111 -> sequence 0,1,0 with instr_done=1 in state 1.
REQ-040 Reset mid-instruction: assert rst_n low between edges while in state 3 -> state=0 immediately and all strobes 0 until release.
